// File: rtl/mux_scan_pkg.sv
// Shared types and widths for the 32:1 mux scan controller and its bank decoder.
package mux_scan_pkg;

    localparam int SEL_W       = 3;
    localparam int CH_PER_BANK = 8;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_FINISH
    } state_t;

endpackage

// File: rtl/mux_bank_decode.sv
// Bank index to active-low one-hot enable; i_force_off turns every bank off.
module mux_bank_decode #(
    parameter int NUM_BANKS = 4,
    parameter int BANK_W    = 2
) (
    input  logic [BANK_W-1:0]    i_bank,
    input  logic                 i_force_off,
    output logic [NUM_BANKS-1:0] o_en_l
);

    always_comb begin
        o_en_l = '1;
        if (!i_force_off) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (i_bank == BANK_W'(b)) begin
                    o_en_l[b] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Sequential scan of a banked 32:1 mux: select, settle, sample each channel, report the word.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   ST_IDLE    | all banks off, waiting for i_start
//   ST_SETTLE  | select/enable held while the analog path settles
//   ST_SAMPLE  | capture i_y for the current channel, advance or finish
//   ST_FINISH  | publish capture to o_q, pulse o_done on the next edge
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int NUM_BANKS = 4,
    parameter int SETTLE    = 2
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic                             i_start,
    input  logic                             i_abort,
    input  logic                             i_y,
    output logic [SEL_W-1:0]                 o_s,
    output logic [NUM_BANKS-1:0]             o_en_l,
    output logic                             o_busy,
    output logic                             o_done,
    output logic [CH_PER_BANK*NUM_BANKS-1:0] o_q
);

    localparam int NUM_CH = CH_PER_BANK * NUM_BANKS;
    localparam int CH_W   = $clog2(NUM_CH);
    localparam int BANK_W = CH_W - SEL_W;

    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(SETTLE - 1);

    state_t                r_state;
    logic [CH_W-1:0]       r_ch;
    logic [CNT_W-1:0]      r_cnt;
    logic [NUM_CH-1:0]     r_cap;
    logic [SEL_W-1:0]      r_s;
    logic [NUM_BANKS-1:0]  r_en_l;
    logic                  r_busy;
    logic                  r_done;
    logic [NUM_CH-1:0]     r_q;

    state_t                w_state_nxt;
    logic [CH_W-1:0]       w_ch_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [NUM_CH-1:0]     w_cap_nxt;
    logic [NUM_CH-1:0]     w_q_nxt;
    logic                  w_done_nxt;
    logic                  w_off;
    logic [SEL_W-1:0]      w_s_nxt;
    logic                  w_busy_nxt;
    logic [NUM_BANKS-1:0]  w_en_l_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_ch_nxt    = r_ch;
        w_cnt_nxt   = r_cnt;
        w_cap_nxt   = r_cap;
        w_q_nxt     = r_q;
        w_done_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // r_done marks the completion cycle, where a new start is refused
                if (i_start && !r_done) begin
                    w_state_nxt = ST_SETTLE;
                    w_ch_nxt    = '0;
                    w_cnt_nxt   = '0;
                    w_cap_nxt   = '0;
                end
            end
            ST_SETTLE: begin
                if (i_abort) begin
                    w_state_nxt = ST_IDLE;
                    w_ch_nxt    = '0;
                    w_cnt_nxt   = '0;
                    w_cap_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_END) begin
                        w_state_nxt = ST_SAMPLE;
                    end
                end
            end
            ST_SAMPLE: begin
                if (i_abort) begin
                    w_state_nxt = ST_IDLE;
                    w_ch_nxt    = '0;
                    w_cnt_nxt   = '0;
                    w_cap_nxt   = '0;
                end else begin
                    w_cap_nxt[r_ch] = i_y;
                    if (r_ch == LAST_CH) begin
                        w_state_nxt = ST_FINISH;
                    end else begin
                        w_state_nxt = ST_SETTLE;
                        w_ch_nxt    = r_ch + CH_W'(1);
                        w_cnt_nxt   = '0;
                    end
                end
            end
            ST_FINISH: begin
                w_state_nxt = ST_IDLE;
                w_q_nxt     = r_cap;
                w_done_nxt  = 1'b1;
                w_ch_nxt    = '0;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Banks go dark as soon as the last sample is taken, keeping every dwell equal.
    assign w_off      = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_FINISH);
    assign w_s_nxt    = w_off ? '0 : w_ch_nxt[SEL_W-1:0];
    assign w_busy_nxt = (w_state_nxt != ST_IDLE);

    mux_bank_decode #(
        .NUM_BANKS (NUM_BANKS),
        .BANK_W    (BANK_W)
    ) u_bank_decode (
        .i_bank      (w_ch_nxt[CH_W-1:SEL_W]),
        .i_force_off (w_off),
        .o_en_l      (w_en_l_nxt)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_ch    <= '0;
            r_cnt   <= '0;
            r_cap   <= '0;
            r_s     <= '0;
            r_en_l  <= '1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_q     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ch    <= w_ch_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cap   <= w_cap_nxt;
            r_s     <= w_s_nxt;
            r_en_l  <= w_en_l_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_q     <= w_q_nxt;
        end
    end

    assign o_s    = r_s;
    assign o_en_l = r_en_l;
    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_q    = r_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: banked mux with settling behaviour, timeline reference per scan.
module tb_mux_scan_ctrl;

    localparam int NB    = 4;
    localparam int ST    = 2;
    localparam int NCH   = 8 * NB;
    localparam int DWELL = ST + 1;
    localparam int T_FIN = NCH * DWELL;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        y;
    logic [2:0]  s;
    logic [3:0]  en_l;
    logic        busy;
    logic        done;
    logic [31:0] q;

    logic [31:0] mux_d;
    logic [2:0]  p_s;
    logic [3:0]  p_en;
    logic [31:0] m_q;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mux_scan_ctrl #(
        .NUM_BANKS (NB),
        .SETTLE    (ST)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_start (start),
        .i_abort (abort),
        .i_y     (y),
        .o_s     (s),
        .o_en_l  (en_l),
        .o_busy  (busy),
        .o_done  (done),
        .o_q     (q)
    );

    // Mux path: output is wrong during the first cycle after any select/enable change.
    always @(posedge clk) begin
        p_s  <= s;
        p_en <= en_l;
    end

    always_comb begin
        logic v;
        v = 1'b0;
        for (int b = 0; b < NB; b++) begin
            if (en_l[b] == 1'b0) v = v | mux_d[8*b + int'(s)];
        end
        y = ((s != p_s) || (en_l != p_en)) ? ~v : v;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag, input logic [31:0] qexp);
        chk({tag, "_s"}, 64'(s), 64'd0);
        chk({tag, "_en_l"}, 64'(en_l), 64'hF);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_q"}, 64'(q), 64'(qexp));
    endtask

    // One scan. j counts edges after the edge that sampled start.
    task automatic run_scan(input logic [31:0] d, input int abort_at, input int reset_at,
                            input int restart_at, input bit abort_with_start);
        int         ch;
        logic [3:0] e_en;
        bit         do_abort;
        bit         do_reset;
        mux_d = d;
        start = 1'b1;
        abort = abort_with_start;
        step();
        start = 1'b0;
        abort = 1'b0;
        for (int j = 0; j <= T_FIN + 2; j++) begin
            if (j < T_FIN) begin
                ch   = j / DWELL;
                e_en = ~(4'b0001 << (ch / 8));
                chk("sel", 64'(s), 64'(ch % 8));
                chk("en_l", 64'(en_l), 64'(e_en));
                chk("busy_scan", 64'(busy), 64'd1);
                chk("done_early", 64'(done), 64'd0);
                chk("q_hold", 64'(q), 64'(m_q));
            end else if (j == T_FIN) begin
                chk("fin_en_l", 64'(en_l), 64'hF);
                chk("fin_s", 64'(s), 64'd0);
                chk("fin_busy", 64'(busy), 64'd1);
                chk("fin_done", 64'(done), 64'd0);
                chk("fin_q_hold", 64'(q), 64'(m_q));
            end else if (j == T_FIN + 1) begin
                chk("done_pulse", 64'(done), 64'd1);
                chk("done_busy", 64'(busy), 64'd0);
                chk("done_en_l", 64'(en_l), 64'hF);
                chk("done_s", 64'(s), 64'd0);
                chk("q_result", 64'(q), 64'(d));
            end else begin
                chk("done_low", 64'(done), 64'd0);
                chk("busy_after", 64'(busy), 64'd0);
                chk("q_after", 64'(q), 64'(d));
                m_q = d;
                return;
            end
            do_abort = (j == abort_at);
            do_reset = (j == reset_at);
            start = (j == restart_at);
            abort = do_abort;
            rst   = do_reset;
            step();
            start = 1'b0;
            abort = 1'b0;
            rst   = 1'b0;
            if (do_reset) begin
                m_q = '0;
                check_idle("reset_mid", m_q);
                step();
                check_idle("reset_after", m_q);
                return;
            end
            if (do_abort) begin
                check_idle("abort", m_q);
                step();
                check_idle("abort_after", m_q);
                return;
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        mux_d = '0;
        m_q   = '0;
        step();
        step();
        check_idle("reset", 32'h0);
        rst = 1'b0;
        step();

        abort = 1'b1;
        step();
        step();
        abort = 1'b0;
        check_idle("abort_idle", 32'h0);

        run_scan(32'hA5C3_0F96, -1, -1, 40, 1'b0);
        run_scan(32'hFFFF_FFFF, 17 * DWELL + 1, -1, -1, 1'b0);
        run_scan(32'h0000_FFFF, -1, -1, T_FIN + 1, 1'b0);
        run_scan($urandom, -1, 20 * DWELL + 1, -1, 1'b0);
        run_scan($urandom, -1, -1, -1, 1'b0);
        run_scan($urandom, -1, -1, -1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            int ab;
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, T_FIN - 1)) : -1;
            run_scan($urandom, ab, -1, int'($urandom_range(0, T_FIN + 1)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
